// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio frame sequencer.
package audio_pkg;

   localparam int DATA_W_DEF  = 32;
   localparam int TIMEOUT_DEF = 4096;

   typedef enum logic [1:0] {
      ST_CAPTURE = 2'd0,
      ST_TX      = 2'd1,
      ST_RX      = 2'd2,
      ST_PLAY    = 2'd3
   } audio_state_e;

   // Saturating 8-bit increment used for the DSP timeout counter.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'hFF) begin
         r = v;
      end else begin
         r = v + 8'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/audio_chan_latch.sv
// One-sample valid/ready holding register for a single ADC channel.
// The ready output is registered: it is high only while the block will be
// capturing and this channel has not yet caught its sample for the frame.
module audio_chan_latch #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_i,      // frame finished, forget held sample
   input  logic              accept_en_i,  // block is capturing next cycle
   input  logic [DATA_W-1:0] in_data_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   output logic              take_o,       // handshake in the current cycle
   output logic              full_o,
   output logic [DATA_W-1:0] data_o
);

   logic              ready_q, ready_d;
   logic              full_q, full_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              take_s;

   assign take_s = in_valid_i && ready_q;

   // Next-state for the held sample, its flag and the registered ready.
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (clear_i) begin
         full_d = 1'b0;
      end else if (take_s) begin
         full_d = 1'b1;
         data_d = in_data_i;
      end else begin
         full_d = full_q;
      end
      ready_d = accept_en_i && !full_d;
   end

   // Holding registers, cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         ready_q <= 1'b0;
         full_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         ready_q <= ready_d;
         full_q  <= full_d;
         data_q  <= data_d;
      end
   end

   assign in_ready_o = ready_q;
   assign take_o     = take_s;
   assign full_o     = full_q;
   assign data_o     = data_q;

endmodule

// File: rtl/audio_frame_sequencer.sv
// Stereo frame sequencer: capture an L/R ADC pair, optionally round-trip it
// through a DSP (with a response timeout), then play it out on the DAC.
module audio_frame_sequencer
   import audio_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] adc_l_data,
   input  logic              adc_l_valid,
   output logic              adc_l_ready,
   input  logic [DATA_W-1:0] adc_r_data,
   input  logic              adc_r_valid,
   output logic              adc_r_ready,
   output logic [DATA_W-1:0] dac_l_data,
   output logic              dac_l_valid,
   input  logic              dac_l_ready,
   output logic [DATA_W-1:0] dac_r_data,
   output logic              dac_r_valid,
   input  logic              dac_r_ready,
   output logic [DATA_W-1:0] proc_tx_l,
   output logic [DATA_W-1:0] proc_tx_r,
   output logic              proc_tx_valid,
   input  logic              proc_tx_ready,
   input  logic [DATA_W-1:0] proc_rx_l,
   input  logic [DATA_W-1:0] proc_rx_r,
   input  logic              proc_rx_valid,
   output logic              proc_rx_ready,
   input  logic              bypass,
   input  logic              mute,
   output logic              busy,
   output logic [15:0]       frame_count,
   output logic [7:0]        timeout_count
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   audio_state_e      state_q, state_d;

   logic              l_take_s, r_take_s, l_full_s, r_full_s;
   logic [DATA_W-1:0] l_held_s, r_held_s, l_smp_s, r_smp_s;
   logic              l_have_s, r_have_s;
   logic              clear_s, accept_en_s;
   logic              tx_hs_s, rx_hs_s, rx_to_s, l_done_s, r_done_s, play_entry_s;

   logic [DATA_W-1:0] proc_tx_l_q, proc_tx_l_d, proc_tx_r_q, proc_tx_r_d;
   logic              proc_tx_valid_q, proc_tx_valid_d;
   logic              proc_rx_ready_q, proc_rx_ready_d;
   logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
   logic [DATA_W-1:0] dac_l_data_q, dac_l_data_d, dac_r_data_q, dac_r_data_d;
   logic              dac_l_valid_q, dac_l_valid_d, dac_r_valid_q, dac_r_valid_d;
   logic              busy_q, busy_d;
   logic [15:0]       frame_count_q, frame_count_d;
   logic [7:0]        timeout_count_q, timeout_count_d;

   audio_chan_latch #(.DATA_W(DATA_W)) u_latch_l (
      .clk         (clk),
      .reset       (reset),
      .clear_i     (clear_s),
      .accept_en_i (accept_en_s),
      .in_data_i   (adc_l_data),
      .in_valid_i  (adc_l_valid),
      .in_ready_o  (adc_l_ready),
      .take_o      (l_take_s),
      .full_o      (l_full_s),
      .data_o      (l_held_s)
   );

   audio_chan_latch #(.DATA_W(DATA_W)) u_latch_r (
      .clk         (clk),
      .reset       (reset),
      .clear_i     (clear_s),
      .accept_en_i (accept_en_s),
      .in_data_i   (adc_r_data),
      .in_valid_i  (adc_r_valid),
      .in_ready_o  (adc_r_ready),
      .take_o      (r_take_s),
      .full_o      (r_full_s),
      .data_o      (r_held_s)
   );

   // A channel counts as latched in the cycle its handshake happens, so the
   // sample is forwarded straight from the ADC bus in that cycle.
   assign l_have_s = l_full_s || l_take_s;
   assign r_have_s = r_full_s || r_take_s;
   assign l_smp_s  = l_take_s ? adc_l_data : l_held_s;
   assign r_smp_s  = r_take_s ? adc_r_data : r_held_s;

   assign tx_hs_s  = proc_tx_valid_q && proc_tx_ready;
   assign rx_hs_s  = proc_rx_ready_q && proc_rx_valid;
   // A response arriving on the last counted cycle wins over the timeout.
   assign rx_to_s  = (state_q == ST_RX) && !rx_hs_s && (rx_cnt_q == CNT_LAST);
   assign l_done_s = !dac_l_valid_q || dac_l_ready;
   assign r_done_s = !dac_r_valid_q || dac_r_ready;

   assign play_entry_s = (state_q != ST_PLAY) && (state_d == ST_PLAY);
   assign clear_s      = (state_q == ST_PLAY) && (state_d == ST_CAPTURE);
   assign accept_en_s  = (state_d == ST_CAPTURE);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_CAPTURE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_CAPTURE: begin
            if (l_have_s && r_have_s) begin
               state_d = bypass ? ST_PLAY : ST_TX;
            end else begin
               state_d = ST_CAPTURE;
            end
         end
         ST_TX: begin
            if (tx_hs_s) begin
               state_d = ST_RX;
            end else begin
               state_d = ST_TX;
            end
         end
         ST_RX: begin
            if (rx_hs_s || rx_to_s) begin
               state_d = ST_PLAY;
            end else begin
               state_d = ST_RX;
            end
         end
         ST_PLAY: begin
            if (l_done_s && r_done_s) begin
               state_d = ST_CAPTURE;
            end else begin
               state_d = ST_PLAY;
            end
         end
         default: state_d = ST_CAPTURE;
      endcase
   end

   // Output/datapath decode: every output is computed one cycle ahead from
   // the next state so that it can be driven straight from a flop.
   always_comb begin
      proc_tx_l_d     = proc_tx_l_q;
      proc_tx_r_d     = proc_tx_r_q;
      dac_l_data_d    = dac_l_data_q;
      dac_r_data_d    = dac_r_data_q;
      frame_count_d   = frame_count_q;
      timeout_count_d = timeout_count_q;

      proc_tx_valid_d = (state_d == ST_TX);
      proc_rx_ready_d = (state_d == ST_RX);
      busy_d          = (state_d != ST_CAPTURE);

      if ((state_q == ST_CAPTURE) && (state_d == ST_TX)) begin
         proc_tx_l_d = l_smp_s;
         proc_tx_r_d = r_smp_s;
      end else begin
         proc_tx_l_d = proc_tx_l_q;
         proc_tx_r_d = proc_tx_r_q;
      end

      if ((state_q == ST_RX) && (state_d == ST_RX)) begin
         rx_cnt_d = rx_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         rx_cnt_d = '0;
      end

      // Mute is only looked at on entry; it then covers the whole frame.
      if (play_entry_s) begin
         if (mute || rx_to_s) begin
            dac_l_data_d = '0;
            dac_r_data_d = '0;
         end else if (state_q == ST_CAPTURE) begin
            dac_l_data_d = l_smp_s;
            dac_r_data_d = r_smp_s;
         end else begin
            dac_l_data_d = proc_rx_l;
            dac_r_data_d = proc_rx_r;
         end
         dac_l_valid_d = 1'b1;
         dac_r_valid_d = 1'b1;
      end else if ((state_q == ST_PLAY) && (state_d == ST_PLAY)) begin
         dac_l_valid_d = dac_l_valid_q && !dac_l_ready;
         dac_r_valid_d = dac_r_valid_q && !dac_r_ready;
      end else begin
         dac_l_valid_d = 1'b0;
         dac_r_valid_d = 1'b0;
      end

      if (clear_s) begin
         frame_count_d = frame_count_q + 16'd1;
      end else begin
         frame_count_d = frame_count_q;
      end

      if (rx_to_s) begin
         timeout_count_d = sat_inc8(timeout_count_q);
      end else begin
         timeout_count_d = timeout_count_q;
      end
   end

   // Output and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         proc_tx_l_q     <= '0;
         proc_tx_r_q     <= '0;
         proc_tx_valid_q <= 1'b0;
         proc_rx_ready_q <= 1'b0;
         rx_cnt_q        <= '0;
         dac_l_data_q    <= '0;
         dac_r_data_q    <= '0;
         dac_l_valid_q   <= 1'b0;
         dac_r_valid_q   <= 1'b0;
         busy_q          <= 1'b0;
         frame_count_q   <= 16'd0;
         timeout_count_q <= 8'd0;
      end else begin
         proc_tx_l_q     <= proc_tx_l_d;
         proc_tx_r_q     <= proc_tx_r_d;
         proc_tx_valid_q <= proc_tx_valid_d;
         proc_rx_ready_q <= proc_rx_ready_d;
         rx_cnt_q        <= rx_cnt_d;
         dac_l_data_q    <= dac_l_data_d;
         dac_r_data_q    <= dac_r_data_d;
         dac_l_valid_q   <= dac_l_valid_d;
         dac_r_valid_q   <= dac_r_valid_d;
         busy_q          <= busy_d;
         frame_count_q   <= frame_count_d;
         timeout_count_q <= timeout_count_d;
      end
   end

   assign proc_tx_l     = proc_tx_l_q;
   assign proc_tx_r     = proc_tx_r_q;
   assign proc_tx_valid = proc_tx_valid_q;
   assign proc_rx_ready = proc_rx_ready_q;
   assign dac_l_data    = dac_l_data_q;
   assign dac_r_data    = dac_r_data_q;
   assign dac_l_valid   = dac_l_valid_q;
   assign dac_r_valid   = dac_r_valid_q;
   assign busy          = busy_q;
   assign frame_count   = frame_count_q;
   assign timeout_count = timeout_count_q;

endmodule
